// File: rtl/cam_pkg.sv
// Shared types for the CAM search sequencer: FSM state encoding and CAM slice read latency.
package cam_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CLR  = 3'd1,
    PUMP = 3'd2,
    CAPT = 3'd3,
    RESP = 3'd4
  } cam_search_state_e;

  // Cycles from the last pump until the accumulated match vector is readable.
  localparam int unsigned CAM_RD_LAT = 1;

endpackage

// File: rtl/cam_search_ctrl_if.sv
// Key-in / result-out handshake bundle for cam_search_ctrl.
// The master drives keys and consumes results; the slave is the sequencer.
interface cam_search_ctrl_if #(
  parameter int BRAM_DEPTH       = 512,
  parameter int CAM_DEPTH        = 64,
  parameter int MULTIPUMP_FACTOR = 2
);
  localparam int ADDR_W    = $clog2(BRAM_DEPTH);
  localparam int IDX_W     = $clog2(CAM_DEPTH);
  localparam int KEY_WIDTH = MULTIPUMP_FACTOR * ADDR_W;

  logic                 key_valid;
  logic                 key_ready;
  logic [KEY_WIDTH-1:0] key_data;
  logic                 res_valid;
  logic                 res_ready;
  logic                 res_hit;
  logic [IDX_W-1:0]     res_index;
  logic                 res_multi;

  modport master (
    output key_valid, key_data, res_ready,
    input  key_ready, res_valid, res_hit, res_index, res_multi
  );

  modport slave (
    input  key_valid, key_data, res_ready,
    output key_ready, res_valid, res_hit, res_index, res_multi
  );

endinterface

// File: rtl/cam_prio_enc.sv
// Combinational priority encoder over the CAM match vector:
// any-hit, lowest set index (0 when empty) and more-than-one-hit flag.
module cam_prio_enc #(
  parameter int CAM_DEPTH = 64
) (
  input  logic [CAM_DEPTH-1:0]         vec,
  output logic                         hit,
  output logic [$clog2(CAM_DEPTH)-1:0] index,
  output logic                         multi
);
  localparam int IDX_W = $clog2(CAM_DEPTH);

  // Scan upward: first set bit fixes the index, any later set bit flags multi-hit.
  always_comb begin
    hit   = 1'b0;
    index = '0;
    multi = 1'b0;
    for (int i = 0; i < CAM_DEPTH; i++) begin
      if (vec[i]) begin
        if (!hit) index = IDX_W'(i);
        else      multi = 1'b1;
        hit = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_search_ctrl.sv
// CAM search sequencer: accepts a key, clears the CAM slice, pumps one address
// chunk per cycle, captures the accumulated match vector and returns an encoded result.
// Optional build macro CAM_SEARCH_VECTOR_EN adds the res_vector output carrying the
// raw captured match vector.
module cam_search_ctrl
  import cam_pkg::*;
#(
  parameter  int BRAM_DEPTH       = 512,
  parameter  int CAM_DEPTH        = 64,
  parameter  int MULTIPUMP_FACTOR = 2,
  localparam int ADDR_W           = $clog2(BRAM_DEPTH),
  localparam int IDX_W            = $clog2(CAM_DEPTH),
  localparam int KEY_WIDTH        = MULTIPUMP_FACTOR * ADDR_W
) (
  input  logic                    clk,
  input  logic                    sys_rstn,
  cam_search_ctrl_if.slave        bus,
  output logic                    rst_cmd,
  output logic                    cam_chip_en,
  output logic                    cam_wr_en,
  output logic [ADDR_W-1:0]       cam_addr,
  output logic                    cam_compare,
  input  logic [CAM_DEPTH-1:0]    cam_rdata
`ifdef CAM_SEARCH_VECTOR_EN
  ,
  output logic [CAM_DEPTH-1:0]    res_vector
`endif
);

  localparam int               CNT_W    = (MULTIPUMP_FACTOR > 1) ? $clog2(MULTIPUMP_FACTOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULTIPUMP_FACTOR - 1);

  cam_search_state_e    r_state;
  cam_search_state_e    w_next;
  logic [KEY_WIDTH-1:0] r_key;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_hit;
  logic [IDX_W-1:0]     r_index;
  logic                 r_multi;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_index;
  logic                 w_multi;
  logic [ADDR_W-1:0]    w_chunk;
  logic                 w_key_acc;

  assign w_key_acc = (r_state == IDLE) && bus.key_valid;
  assign cam_wr_en = 1'b0;

  // State register; reset aborts any in-flight search.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) r_state <= IDLE;
    else           r_state <= w_next;
  end

  // Next-state and per-state decode of handshake and CAM pins.
  always_comb begin
    w_next        = r_state;
    bus.key_ready = 1'b0;
    bus.res_valid = 1'b0;
    rst_cmd       = 1'b0;
    cam_chip_en   = 1'b0;
    cam_compare   = 1'b0;
    cam_addr      = '0;
    case (r_state)
      IDLE: begin
        bus.key_ready = 1'b1;
        if (bus.key_valid) w_next = CLR;
      end
      CLR: begin
        rst_cmd = 1'b1;
        w_next  = PUMP;
      end
      PUMP: begin
        cam_chip_en = 1'b1;
        cam_compare = 1'b1;
        cam_addr    = w_chunk;
        if (r_cnt == CNT_LAST) w_next = CAPT;
      end
      CAPT: w_next = RESP;
      RESP: begin
        bus.res_valid = 1'b1;
        if (bus.res_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Select the key chunk addressed by the pump counter, chunk 0 in the low bits.
  always_comb begin
    w_chunk = '0;
    for (int i = 0; i < MULTIPUMP_FACTOR; i++) begin
      if (r_cnt == CNT_W'(i)) w_chunk = r_key[i*ADDR_W +: ADDR_W];
    end
  end

  // Key holding register: loaded only on an accepted key, no reset needed.
  always_ff @(posedge clk) begin
    if (w_key_acc) r_key <= bus.key_data;
  end

  // Pump counter: cleared in CLR, saturates at the last chunk.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn)                                r_cnt <= '0;
    else if (r_state == CLR)                      r_cnt <= '0;
    else if (r_state == PUMP && r_cnt != CNT_LAST) r_cnt <= r_cnt + 1'b1;
  end

  cam_prio_enc #(
    .CAM_DEPTH (CAM_DEPTH)
  ) u_prio_enc (
    .vec   (cam_rdata),
    .hit   (w_hit),
    .index (w_index),
    .multi (w_multi)
  );

  // Result registers: loaded from the encoder in CAPT, held through RESP.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      r_hit   <= 1'b0;
      r_index <= '0;
      r_multi <= 1'b0;
    end else if (r_state == CAPT) begin
      r_hit   <= w_hit;
      r_index <= w_index;
      r_multi <= w_multi;
    end
  end

  assign bus.res_hit   = r_hit;
  assign bus.res_index = r_index;
  assign bus.res_multi = r_multi;

`ifdef CAM_SEARCH_VECTOR_EN
  logic [CAM_DEPTH-1:0] r_vec;

  // Raw match vector captured alongside the encoded result.
  always_ff @(posedge clk or negedge sys_rstn) begin
    if (!sys_rstn)            r_vec <= '0;
    else if (r_state == CAPT) r_vec <= cam_rdata;
  end

  assign res_vector = r_vec;
`endif

endmodule

// File: tb/tb_cam_search_ctrl.sv
// Directed bench for cam_search_ctrl (default parameters, F=2).
module tb_cam_search_ctrl;

  logic        clk = 1'b0;
  logic        sys_rstn;
  logic        rst_cmd;
  logic        cam_chip_en;
  logic        cam_wr_en;
  logic [8:0]  cam_addr;
  logic        cam_compare;
  logic [63:0] cam_rdata;
`ifdef CAM_SEARCH_VECTOR_EN
  logic [63:0] res_vector;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cam_search_ctrl_if bus ();

  cam_search_ctrl dut (
    .clk         (clk),
    .sys_rstn    (sys_rstn),
    .bus         (bus),
    .rst_cmd     (rst_cmd),
    .cam_chip_en (cam_chip_en),
    .cam_wr_en   (cam_wr_en),
    .cam_addr    (cam_addr),
    .cam_compare (cam_compare),
    .cam_rdata   (cam_rdata)
`ifdef CAM_SEARCH_VECTOR_EN
    ,
    .res_vector  (res_vector)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    sys_rstn      = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.res_ready = 1'b0;
    cam_rdata     = '0;
    #12;
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL reset_key_ready got %b want 1", bus.key_ready); end
    checks++; if ({rst_cmd, cam_chip_en, cam_wr_en, cam_compare} !== 4'b0000) begin errors++; $display("FAIL reset_cam_pins got %b want 0000", {rst_cmd, cam_chip_en, cam_wr_en, cam_compare}); end
    checks++; if (cam_addr !== 9'h000) begin errors++; $display("FAIL reset_cam_addr got %h want 000", cam_addr); end
    checks++; if ({bus.res_valid, bus.res_hit, bus.res_multi} !== 3'b000) begin errors++; $display("FAIL reset_res_flags got %b want 000", {bus.res_valid, bus.res_hit, bus.res_multi}); end
    checks++; if (bus.res_index !== 6'd0) begin errors++; $display("FAIL reset_res_index got %0d want 0", bus.res_index); end
    @(negedge clk);
    sys_rstn = 1'b1;
    step();
  endtask

  // One full search starting in IDLE; returns in IDLE one cycle after the result handshake.
  task automatic search(input logic [8:0] a0, input logic [8:0] a1, input logic [63:0] vec,
                        input logic eh, input logic [5:0] ei, input logic em);
    checks++; if (bus.key_ready !== 1'b1) begin errors++; $display("FAIL idle_key_ready got %b want 1", bus.key_ready); end
    bus.key_valid = 1'b1;
    bus.key_data  = {a1, a0};
    bus.res_ready = 1'b1;
    cam_rdata     = ~vec;
    step(); // CLR
    bus.key_valid = 1'b0;
    bus.key_data  = '1;
    checks++; if ({rst_cmd, cam_chip_en, cam_compare, bus.key_ready} !== 4'b1000) begin errors++; $display("FAIL clr_pins got %b want 1000", {rst_cmd, cam_chip_en, cam_compare, bus.key_ready}); end
    step(); // pump 0
    checks++; if ({rst_cmd, cam_chip_en, cam_compare, cam_wr_en} !== 4'b0110) begin errors++; $display("FAIL pump0_pins got %b want 0110", {rst_cmd, cam_chip_en, cam_compare, cam_wr_en}); end
    checks++; if (cam_addr !== a0) begin errors++; $display("FAIL pump0_addr got %h want %h", cam_addr, a0); end
    step(); // pump 1
    checks++; if ({cam_chip_en, cam_compare} !== 2'b11) begin errors++; $display("FAIL pump1_pins got %b want 11", {cam_chip_en, cam_compare}); end
    checks++; if (cam_addr !== a1) begin errors++; $display("FAIL pump1_addr got %h want %h", cam_addr, a1); end
    step(); // CAPT
    cam_rdata = vec;
    checks++; if ({rst_cmd, cam_chip_en, cam_compare, bus.res_valid, bus.key_ready} !== 5'b00000) begin errors++; $display("FAIL capt_pins got %b want 00000", {rst_cmd, cam_chip_en, cam_compare, bus.res_valid, bus.key_ready}); end
    step(); // RESP
    cam_rdata = ~vec;
    checks++; if (bus.res_valid !== 1'b1) begin errors++; $display("FAIL resp_valid got %b want 1", bus.res_valid); end
    checks++; if ({bus.res_hit, bus.res_multi} !== {eh, em}) begin errors++; $display("FAIL resp_hit_multi got %b want %b", {bus.res_hit, bus.res_multi}, {eh, em}); end
    checks++; if (bus.res_index !== ei) begin errors++; $display("FAIL resp_index got %0d want %0d", bus.res_index, ei); end
`ifdef CAM_SEARCH_VECTOR_EN
    checks++; if (res_vector !== vec) begin errors++; $display("FAIL resp_vector got %h want %h", res_vector, vec); end
`endif
    step(); // back in IDLE
    bus.res_ready = 1'b0;
    checks++; if ({bus.res_valid, bus.key_ready} !== 2'b01) begin errors++; $display("FAIL post_resp got %b want 01", {bus.res_valid, bus.key_ready}); end
  endtask

  task automatic test_search_patterns();
    search(9'h1F3, 9'h0A5, 64'h0000_0000_0000_0100, 1'b1, 6'd8,  1'b0);
    search(9'h000, 9'h1FF, 64'h8000_0000_0000_0011, 1'b1, 6'd0,  1'b1);
    search(9'h123, 9'h045, 64'h0000_0000_0000_0000, 1'b0, 6'd0,  1'b0);
    search(9'h0F0, 9'h10F, 64'h8000_0000_0000_0000, 1'b1, 6'd63, 1'b0);
  endtask

  task automatic test_async_reset();
    bus.key_valid = 1'b1;
    bus.key_data  = {9'h055, 9'h0AA};
    step(); // CLR
    bus.key_valid = 1'b0;
    step(); // pump 0
    step(); // pump 1
    #2;
    sys_rstn = 1'b0;
    #1;
    checks++; if ({rst_cmd, cam_chip_en, cam_compare, cam_wr_en} !== 4'b0000) begin errors++; $display("FAIL arst_cam_pins got %b want 0000", {rst_cmd, cam_chip_en, cam_compare, cam_wr_en}); end
    checks++; if (cam_addr !== 9'h000) begin errors++; $display("FAIL arst_addr got %h want 000", cam_addr); end
    checks++; if ({bus.key_ready, bus.res_valid, bus.res_hit, bus.res_multi} !== 4'b1000) begin errors++; $display("FAIL arst_res got %b want 1000", {bus.key_ready, bus.res_valid, bus.res_hit, bus.res_multi}); end
    checks++; if (bus.res_index !== 6'd0) begin errors++; $display("FAIL arst_index got %0d want 0", bus.res_index); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    sys_rstn = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      checks++; if ({bus.res_valid, rst_cmd, cam_chip_en, bus.key_ready} !== 4'b0001) begin errors++; $display("FAIL arst_idle got %b want 0001", {bus.res_valid, rst_cmd, cam_chip_en, bus.key_ready}); end
      step();
    end
    search(9'h0AA, 9'h055, 64'h0000_0001_0000_0000, 1'b1, 6'd32, 1'b0);
  endtask

  task automatic test_backpressure();
    bus.key_valid = 1'b1;
    bus.key_data  = {9'h003, 9'h1FF};
    bus.res_ready = 1'b0;
    step(); // CLR; next key presented early must be ignored
    bus.key_data = {9'h111, 9'h022};
    step(); // pump 0
    checks++; if (cam_addr !== 9'h1FF) begin errors++; $display("FAIL bp_pump0_addr got %h want 1FF", cam_addr); end
    step(); // pump 1
    checks++; if (cam_addr !== 9'h003) begin errors++; $display("FAIL bp_pump1_addr got %h want 003", cam_addr); end
    step(); // CAPT
    cam_rdata = 64'h0000_0000_0000_0030;
    step(); // RESP
    cam_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      checks++; if ({bus.res_valid, bus.key_ready, bus.res_hit, bus.res_multi} !== 4'b1011) begin errors++; $display("FAIL bp_hold_flags got %b want 1011", {bus.res_valid, bus.key_ready, bus.res_hit, bus.res_multi}); end
      checks++; if (bus.res_index !== 6'd4) begin errors++; $display("FAIL bp_hold_index got %0d want 4", bus.res_index); end
      step();
    end
    bus.res_ready = 1'b1;
    checks++; if (bus.key_ready !== 1'b0) begin errors++; $display("FAIL bp_exit_key_ready got %b want 0", bus.key_ready); end
    step(); // IDLE, second key accepted here
    bus.res_ready = 1'b0;
    checks++; if ({bus.key_ready, bus.res_valid} !== 2'b10) begin errors++; $display("FAIL bp_idle got %b want 10", {bus.key_ready, bus.res_valid}); end
    step(); // CLR
    bus.key_valid = 1'b0;
    checks++; if (rst_cmd !== 1'b1) begin errors++; $display("FAIL bp2_clr got %b want 1", rst_cmd); end
    step();
    checks++; if (cam_addr !== 9'h022) begin errors++; $display("FAIL bp2_pump0_addr got %h want 022", cam_addr); end
    step();
    checks++; if (cam_addr !== 9'h111) begin errors++; $display("FAIL bp2_pump1_addr got %h want 111", cam_addr); end
    step(); // CAPT
    cam_rdata = 64'h0000_0000_0000_0000;
    step(); // RESP
    checks++; if ({bus.res_valid, bus.res_hit, bus.res_multi} !== 3'b100) begin errors++; $display("FAIL bp2_resp got %b want 100", {bus.res_valid, bus.res_hit, bus.res_multi}); end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_search_patterns();
    test_async_reset();
    test_backpressure();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cam_search_ctrl.md
# cam_search_ctrl

Search sequencer that sits directly upstream of the BRAM CAM slice. It accepts a search key over a valid/ready handshake and splits it into MULTIPUMP_FACTOR address chunks. It drives the CAM slice's chip-enable, address, compare and reset-command pins for one pump per chunk, then captures the AND-accumulated match vector. It priority-encodes that vector and returns hit/index/multi-hit over a second valid/ready handshake.

## Interface
- BRAM_DEPTH, 512, CAM slice BRAM depth; ADDR_W = $clog2(BRAM_DEPTH) (localparam)
- CAM_DEPTH, 64, entries per CAM slice (match vector width); IDX_W = $clog2(CAM_DEPTH) (localparam)
- MULTIPUMP_FACTOR, 2, chunks per key; KEY_WIDTH = MULTIPUMP_FACTOR*ADDR_W (localparam)
- clk  in  1  single clock
- sys_rstn  in  1  asynchronous, active-low reset
- key_valid  in  1  search key present
- key_ready  out  1  block idle, key accepted on key_valid&key_ready
- key_data  in  KEY_WIDTH  search key; chunk i = key_data[i*ADDR_W +: ADDR_W]
- rst_cmd  out  1  one-cycle clear of CAM slice accumulators/counters
- cam_chip_en  out  1  CAM BRAM enable
- cam_wr_en  out  1  tied 0 (search only)
- cam_addr  out  ADDR_W  current chunk
- cam_compare  out  1  accumulate enable
- cam_rdata  in  CAM_DEPTH  accumulated match vector from CAM slice
- res_valid  out  1  result available
- res_ready  in  1  consumer takes result
- res_hit  out  1  any entry matched
- res_index  out  IDX_W  lowest matching entry index
- res_multi  out  1  more than one entry matched

## Operation
- FSM states: IDLE, CLR, PUMP, CAPT, RESP.
- IDLE: key_ready=1; on handshake latch key_data into key register -> CLR.
- CLR: rst_cmd=1, all other CAM outputs 0 -> PUMP, pump counter = 0.
- PUMP: cam_chip_en=1, cam_compare=1, cam_addr = chunk[cnt]; chunk 0 first. cnt increments each cycle. At cnt == MULTIPUMP_FACTOR-1 -> CAPT.
- CAPT: CAM outputs 0. Sample cam_rdata (read data of last pump, 1-cycle BRAM read latency). Register the encoder output -> RESP.
- RESP: res_valid=1, result held stable; on res_ready -> IDLE.
- Encoding: res_hit = |vec; res_index = lowest set bit, 0 when no hit; res_multi = popcount(vec) > 1.
- Pump counter width $clog2(MULTIPUMP_FACTOR), minimum 1 bit. It never wraps past MULTIPUMP_FACTOR-1.
- key_data ignored outside the IDLE handshake; key register holds the value until the next accept.

## Timing
- Reset: state=IDLE; key_ready=1; rst_cmd, cam_chip_en, cam_wr_en, cam_compare, cam_addr, res_valid, res_hit, res_index, res_multi all 0.
- Accept at cycle 0; rst_cmd cycle 1; pumps cycles 2..F+1; capture cycle F+2; res_valid from cycle F+3. F=2: result visible cycle 5.
- Throughput: one search per F+4 cycles minimum; key_ready=0 from CLR through RESP.
- No accept in the RESP-exit cycle; key_ready returns the cycle after the res handshake.
- res_ready low: stay in RESP indefinitely, outputs constant.
- res_ready high while not res_valid: ignored.
- sys_rstn asserted in any state: immediate return to reset values. The in-flight search is discarded and no result is produced.

## Configuration
- CAM_SEARCH_VECTOR_EN defined: adds output port res_vector [CAM_DEPTH-1:0], the raw captured match vector. It is registered in CAPT, held through RESP, and reset to 0.
- Macro undefined: port absent; vector used only combinationally in CAPT, with no vector register.

## Structure
- Shared package cam_pkg: FSM state enum cam_search_state_e and CAM_RD_LAT = 1.
- Sub-module cam_prio_enc: combinational, parameter CAM_DEPTH; outputs hit, index, multi.

## Test plan
- F=2, key_data = {9'h0A5, 9'h1F3} -> rst_cmd cycle 1, cam_addr 9'h1F3 cycle 2, 9'h0A5 cycle 3, cam_compare=1 both cycles.
- Model returns cam_rdata = 64'h0000_0000_0000_0100 in CAPT -> cycle 5: res_valid=1, hit=1, index=8, multi=0.
- cam_rdata = 64'h8000_0000_0000_0011 -> hit=1, index=0, multi=1; with CAM_SEARCH_VECTOR_EN, res_vector equals the same value.
- cam_rdata = 0 -> hit=0, index=0, multi=0.
- res_ready low 10 cycles, key_valid held high -> result constant, key_ready=0; res_ready pulse -> key_ready=1 next cycle, second key accepted.
- sys_rstn low during second pump -> all outputs 0 asynchronously. Next key runs full CLR/PUMP sequence; no stale result.
